// File: rtl/cordic_txn_driver.sv
// Sequencing stage for the cordiccart2pol core: accepts operand pairs, drives the
// ap_ctrl_hs handshake, and returns results with start-to-done latency and timeout flag.
module cordic_txn_driver #(
  parameter int IN_W        = 12,
  parameter int OUT_W       = 12,
  parameter int LAT_W       = 16,
  parameter int TIMEOUT_CYC = 1000,
  parameter int CNT_W       = 32
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_x,
  input  logic [IN_W-1:0]  s_y,
  output logic             cordic_start,
  input  logic             cordic_ready,
  input  logic             cordic_done,
  output logic [IN_W-1:0]  cordic_x,
  output logic [IN_W-1:0]  cordic_y,
  input  logic [OUT_W-1:0] cordic_r,
  input  logic [OUT_W-1:0] cordic_theta,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_r,
  output logic [OUT_W-1:0] m_theta,
  output logic [LAT_W-1:0] m_latency,
  output logic             m_err,
  output logic [CNT_W-1:0] txn_count,
  output logic             err_sticky
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT_DONE,
    OUT
  } state_t;

  localparam logic [LAT_W-1:0] LAT_MAX = '1;
  localparam logic [LAT_W-1:0] TO_LAST = LAT_W'(TIMEOUT_CYC - 1);

  state_t state;
  state_t state_nx;

  logic [LAT_W-1:0] lat_cnt;
  logic             busy;
  logic             accept;
  logic             capture;
  logic             abort;
  logic             out_hs;

  assign busy    = (state == START) || (state == WAIT_DONE);
  assign s_ready = (state == IDLE);
  assign m_valid = (state == OUT);
  assign accept  = s_valid && s_ready;
  assign out_hs  = m_valid && m_ready;

  assign cordic_start = (state == START);

  // A done inside START only counts once the core has taken the start.
  assign capture = ((state == START) && cordic_ready && cordic_done)
                || ((state == WAIT_DONE) && cordic_done);

  // Done in the timeout cycle wins over the abort.
  assign abort = busy && !capture && (lat_cnt == TO_LAST);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = START;
      end
      START: begin
        if (capture || abort) state_nx = OUT;
        else if (cordic_ready) state_nx = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (capture || abort) state_nx = OUT;
      end
      OUT: begin
        if (out_hs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      cordic_x <= '0;
      cordic_y <= '0;
    end else if (accept) begin
      cordic_x <= s_x;
      cordic_y <= s_y;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      lat_cnt <= '0;
    end else if (accept) begin
      lat_cnt <= '0;
    end else if (busy && (lat_cnt != LAT_MAX)) begin
      lat_cnt <= lat_cnt + 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_r       <= '0;
      m_theta   <= '0;
      m_latency <= '0;
    end else if (capture) begin
      m_r       <= cordic_r;
      m_theta   <= cordic_theta;
      m_latency <= lat_cnt;
    end else if (abort) begin
      m_r       <= '0;
      m_theta   <= '0;
      m_latency <= TO_LAST;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      m_err      <= 1'b0;
      err_sticky <= 1'b0;
    end else begin
      if (abort) begin
        m_err      <= 1'b1;
        err_sticky <= 1'b1;
      end else if (out_hs) begin
        m_err <= 1'b0;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      txn_count <= '0;
    end else if (out_hs) begin
      txn_count <= txn_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_cordic_txn_driver.sv
// Self-checking bench for cordic_txn_driver: directed table, randomized
// transactions against a latency/timeout reference model, and reset corner case.
module tb_cordic_txn_driver;

  localparam int IN_W  = 12;
  localparam int OUT_W = 12;
  localparam int LAT_W = 16;
  localparam int TO    = 24;
  localparam int CNT_W = 32;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n;
  logic             s_valid;
  logic             s_ready;
  logic [IN_W-1:0]  s_x;
  logic [IN_W-1:0]  s_y;
  logic             cordic_start;
  logic             cordic_ready;
  logic             cordic_done;
  logic [IN_W-1:0]  cordic_x;
  logic [IN_W-1:0]  cordic_y;
  logic [OUT_W-1:0] cordic_r;
  logic [OUT_W-1:0] cordic_theta;
  logic             m_valid;
  logic             m_ready;
  logic [OUT_W-1:0] m_r;
  logic [OUT_W-1:0] m_theta;
  logic [LAT_W-1:0] m_latency;
  logic             m_err;
  logic [CNT_W-1:0] txn_count;
  logic             err_sticky;

  cordic_txn_driver #(
    .IN_W(IN_W), .OUT_W(OUT_W), .LAT_W(LAT_W),
    .TIMEOUT_CYC(TO), .CNT_W(CNT_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y),
    .cordic_start(cordic_start), .cordic_ready(cordic_ready),
    .cordic_done(cordic_done), .cordic_x(cordic_x), .cordic_y(cordic_y),
    .cordic_r(cordic_r), .cordic_theta(cordic_theta),
    .m_valid(m_valid), .m_ready(m_ready), .m_r(m_r), .m_theta(m_theta),
    .m_latency(m_latency), .m_err(m_err),
    .txn_count(txn_count), .err_sticky(err_sticky)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] r;
    logic [11:0] th;
    int          rd;
    int          dd;
    int          md;
    int          lat;
    bit          err;
    int          starts;
  } vec_t;

  int  n_pass = 0;
  int  n_tot  = 0;
  int  exp_cnt = 0;
  bit  exp_sticky = 1'b0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: result ends at done cycle, or aborts at the last allowed cycle.
  function automatic vec_t model(input vec_t v);
    vec_t o = v;
    int   last;
    if (v.dd >= 0 && v.dd <= TO - 1 && v.dd >= v.rd) begin
      o.lat = v.dd;
      o.err = 1'b0;
    end else begin
      o.lat = TO - 1;
      o.err = 1'b1;
    end
    last = o.lat;
    o.starts = ((v.rd < last) ? v.rd : last) + 1;
    return o;
  endfunction

  task automatic run_txn(input vec_t v);
    int  n;
    int  k;
    int  starts;
    bit  hold_bad;
    bit  bp_bad;
    logic [11:0] er;
    logic [11:0] et;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge ap_clk);
      n++;
    end
    chk("s_ready_idle", 64'(s_ready), 64'(1));
    s_valid = 1'b1;
    s_x = v.x;
    s_y = v.y;
    @(negedge ap_clk);
    s_valid = 1'b0;
    s_x = 12'($urandom);
    s_y = 12'($urandom);
    k = 0;
    starts = 0;
    hold_bad = 1'b0;
    while (!m_valid && k < 200) begin
      if (cordic_start) starts++;
      if (cordic_x !== v.x || cordic_y !== v.y) hold_bad = 1'b1;
      cordic_ready = (k == v.rd);
      cordic_done  = (k == v.dd);
      cordic_r     = (k == v.dd) ? v.r : 12'($urandom);
      cordic_theta = (k == v.dd) ? v.th : 12'($urandom);
      @(negedge ap_clk);
      k++;
    end
    cordic_ready = 1'b0;
    cordic_done  = 1'b0;
    er = v.err ? 12'h0 : v.r;
    et = v.err ? 12'h0 : v.th;
    if (v.err) exp_sticky = 1'b1;
    chk("m_valid_up", 64'(m_valid), 64'(1));
    chk("start_cycles", 64'(starts), 64'(v.starts));
    chk("operand_hold", 64'(hold_bad), 64'(0));
    chk("m_r", 64'(m_r), 64'(er));
    chk("m_theta", 64'(m_theta), 64'(et));
    chk("m_latency", 64'(m_latency), 64'(v.lat));
    chk("m_err", 64'(m_err), 64'(v.err));
    chk("err_sticky", 64'(err_sticky), 64'(exp_sticky));
    s_valid = 1'b1;
    s_x = ~v.x;
    s_y = ~v.y;
    bp_bad = 1'b0;
    for (int i = 0; i < v.md; i++) begin
      cordic_done = 1'b1;
      @(negedge ap_clk);
      if (!m_valid || s_ready || cordic_start || m_r !== er || m_theta !== et
          || m_latency !== LAT_W'(v.lat) || cordic_x !== v.x
          || txn_count !== CNT_W'(exp_cnt)) bp_bad = 1'b1;
    end
    cordic_done = 1'b0;
    if (v.md > 0) chk("backpressure_hold", 64'(bp_bad), 64'(0));
    m_ready = 1'b1;
    @(negedge ap_clk);
    m_ready = 1'b0;
    s_valid = 1'b0;
    exp_cnt++;
    chk("txn_count", 64'(txn_count), 64'(CNT_W'(exp_cnt)));
    chk("post_hs_idle", {m_valid, cordic_start, s_ready, m_err},
        64'(4'b0010));
    chk("post_hs_x", 64'(cordic_x), 64'(v.x));
  endtask

  vec_t tbl[7];
  vec_t v;

  initial begin
    ap_rst_n = 1'b0;
    s_valid = 1'b0;
    s_x = '0;
    s_y = '0;
    cordic_ready = 1'b0;
    cordic_done = 1'b0;
    cordic_r = '0;
    cordic_theta = '0;
    m_ready = 1'b0;

    tbl[0] = '{12'h100, 12'h000, 12'h100, 12'h000, 1, 19, 0, 19, 1'b0, 2};
    tbl[1] = '{12'h3C2, 12'h7F1, 12'h5A5, 12'h321, 0, 0, 3, 0, 1'b0, 1};
    tbl[2] = '{12'h011, 12'h022, 12'hABC, 12'h123, 2, 6, 10, 6, 1'b0, 3};
    tbl[3] = '{12'h444, 12'h555, 12'h777, 12'h666, 1, -1, 2, 23, 1'b1, 2};
    tbl[4] = '{12'h0F0, 12'h00F, 12'h9E3, 12'h3E9, 0, 23, 0, 23, 1'b0, 1};
    tbl[5] = '{12'hFFF, 12'h800, 12'h111, 12'h222, 99, -1, 1, 23, 1'b1, 24};
    tbl[6] = '{12'h001, 12'hFFE, 12'h333, 12'h444, 0, 24, 0, 23, 1'b1, 1};

    #1;
    chk("rst_outputs",
        {s_ready, cordic_start, m_valid, m_err, err_sticky},
        64'(5'b10000));
    chk("rst_data", {txn_count, m_latency, m_r, cordic_x},
        64'(0));
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);

    for (int i = 0; i < 7; i++) run_txn(tbl[i]);

    for (int i = 0; i < 5; i++) begin
      v.x = 12'(i + 1);
      v.y = 12'(i * 3);
      v.r = 12'(16 * i + 5);
      v.th = 12'(i);
      v.rd = 0;
      v.dd = 2;
      v.md = 0;
      run_txn(model(v));
    end

    for (int i = 0; i < 20; i++) begin
      v.x = 12'($urandom);
      v.y = 12'($urandom);
      v.r = 12'($urandom);
      v.th = 12'($urandom);
      v.rd = int'($urandom_range(0, 5));
      v.dd = ($urandom_range(0, 4) == 0) ? -1
           : v.rd + int'($urandom_range(0, 25));
      v.md = int'($urandom_range(0, 4));
      run_txn(model(v));
    end

    s_valid = 1'b1;
    s_x = 12'h2AA;
    s_y = 12'h155;
    @(negedge ap_clk);
    s_valid = 1'b0;
    cordic_ready = 1'b1;
    @(negedge ap_clk);
    cordic_ready = 1'b0;
    repeat (3) @(negedge ap_clk);
    chk("pre_rst_busy", {s_ready, m_valid, cordic_start}, 64'(0));
    #2 ap_rst_n = 1'b0;
    #1;
    chk("async_rst", {s_ready, cordic_start, m_valid, m_err, err_sticky},
        64'(5'b10000));
    chk("async_rst_data", {txn_count, cordic_x, cordic_y, m_latency},
        64'(0));
    #9 ap_rst_n = 1'b1;
    exp_cnt = 0;
    exp_sticky = 1'b0;
    @(negedge ap_clk);
    cordic_done = 1'b1;
    cordic_r = 12'hBAD;
    @(negedge ap_clk);
    cordic_done = 1'b0;
    @(negedge ap_clk);
    chk("late_done_ignored", {s_ready, m_valid, cordic_start, err_sticky},
        64'(4'b1000));
    chk("late_done_data", {txn_count, m_r}, 64'(0));

    run_txn(tbl[3]);
    run_txn(tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
